// File: rtl/isdu_ctrl.sv
// Instruction sequencing / decode control unit for a small 16-bit CPU datapath.
// Moore FSM driving load strobes, bus gates and mux selects; memory accesses last MEM_WAIT cycles.
module isdu_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ALUK,
  output logic       SR2MUX,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] dbg_state
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP,
    S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_PAUSE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          cont_low, cont_low_d;
  logic          in_wait, wait_last;

  assign dbg_state = state;
  assign in_wait   = (state == S_FETCH2) || (state == S_LDR2) || (state == S_STR2);
  assign wait_last = (cnt == LAST);

  // Every wait state is entered from a non-wait state, so the counter is 0 on entry
  // and stops at MEM_WAIT-1.
  assign cnt_d = (in_wait && !wait_last) ? cnt + CW'(1) : '0;

  // Remembers that Continue was seen low during the current PAUSE visit.
  assign cont_low_d = (state == S_PAUSE) ? (cont_low | ~Continue) : 1'b0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_HALTED;
      cnt      <= '0;
      cont_low <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cont_low <= cont_low_d;
    end
  end

  always_comb begin
    state_d    = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    ALUK       = 2'b00;
    SR2MUX     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S_HALTED: if (Run) state_d = S_FETCH1;
      S_FETCH1: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        LD_PC   = 1'b1;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        Mem_OE = 1'b1;
        LD_MDR = wait_last;
        if (wait_last) state_d = S_FETCH3;
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b0000: state_d = S_BR;
          4'b1100: state_d = S_JMP;
          4'b0110: state_d = S_LDR1;
          4'b0111: state_d = S_STR1;
          4'b1101: state_d = S_PAUSE;
          default: state_d = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
        state_d = S_FETCH1;
      end
      S_BR: state_d = BEN ? S_BR_TAKEN : S_FETCH1;
      S_BR_TAKEN: begin
        LD_PC   = 1'b1;
        PCMUX   = 2'b10;
        state_d = S_FETCH1;
      end
      S_JMP: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_PC   = 1'b1;
        PCMUX   = 2'b01;
        state_d = S_FETCH1;
      end
      S_LDR1: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        state_d    = S_LDR2;
      end
      S_LDR2: begin
        Mem_OE = 1'b1;
        LD_MDR = wait_last;
        if (wait_last) state_d = S_LDR3;
      end
      S_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = S_FETCH1;
      end
      // MDR captures the source register through the ALU pass path.
      S_STR1: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        LD_MDR     = 1'b1;
        ALUK       = 2'b11;
        state_d    = S_STR2;
      end
      S_STR2: begin
        Mem_WE = 1'b1;
        if (wait_last) state_d = S_FETCH1;
      end
      S_PAUSE: if (Continue && cont_low) state_d = S_FETCH1;
      default: state_d = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_isdu_ctrl.sv
// Directed bench for isdu_ctrl: two instances (MEM_WAIT 2 and 3), per-cycle output
// vectors predicted into a queue and checked on the falling edge.
module tb_isdu_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n, Run_a, Run_b, Continue, IR_5, BEN;
  logic [3:0] Opcode;
  logic       sel;

  always #5 Clk = ~Clk;

  // {LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,GatePC,GateMDR,GateALU,GateMARMUX,PCMUX,ALUK,SR2MUX,Mem_OE,Mem_WE}
  logic [17:0] va, vb;
  logic [4:0]  st_a, st_b;

  isdu_ctrl #(.MEM_WAIT(2)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run_a), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(va[17]), .LD_MDR(va[16]), .LD_IR(va[15]), .LD_BEN(va[14]), .LD_CC(va[13]),
    .LD_REG(va[12]), .LD_PC(va[11]), .GatePC(va[10]), .GateMDR(va[9]), .GateALU(va[8]),
    .GateMARMUX(va[7]), .PCMUX(va[6:5]), .ALUK(va[4:3]), .SR2MUX(va[2]),
    .Mem_OE(va[1]), .Mem_WE(va[0]), .dbg_state(st_a)
  );

  isdu_ctrl #(.MEM_WAIT(3)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run_b), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .BEN(BEN),
    .LD_MAR(vb[17]), .LD_MDR(vb[16]), .LD_IR(vb[15]), .LD_BEN(vb[14]), .LD_CC(vb[13]),
    .LD_REG(vb[12]), .LD_PC(vb[11]), .GatePC(vb[10]), .GateMDR(vb[9]), .GateALU(vb[8]),
    .GateMARMUX(vb[7]), .PCMUX(vb[6:5]), .ALUK(vb[4:3]), .SR2MUX(vb[2]),
    .Mem_OE(vb[1]), .Mem_WE(vb[0]), .dbg_state(st_b)
  );

  localparam logic [17:0] L_MAR = 18'd1 << 17, L_MDR = 18'd1 << 16, L_IR = 18'd1 << 15;
  localparam logic [17:0] L_BEN = 18'd1 << 14, L_CC = 18'd1 << 13, L_REG = 18'd1 << 12;
  localparam logic [17:0] L_PC = 18'd1 << 11, G_PC = 18'd1 << 10, G_MDR = 18'd1 << 9;
  localparam logic [17:0] G_ALU = 18'd1 << 8, G_MMX = 18'd1 << 7, SR2 = 18'd1 << 2;
  localparam logic [17:0] M_OE = 18'd1 << 1, M_WE = 18'd1;
  localparam logic [17:0] PC_BUS = 18'd1 << 5, PC_OFF = 18'd2 << 5;
  localparam logic [17:0] K_AND = 18'd1 << 3, K_NOT = 18'd2 << 3, K_PASS = 18'd3 << 3;

  localparam logic [17:0] E_ZERO = 18'd0;
  localparam logic [17:0] E_F1   = G_PC | L_MAR | L_PC;
  localparam logic [17:0] E_MRD  = M_OE;
  localparam logic [17:0] E_MRDL = M_OE | L_MDR;
  localparam logic [17:0] E_F3   = G_MDR | L_IR;
  localparam logic [17:0] E_DEC  = L_BEN;
  localparam logic [17:0] E_BRT  = L_PC | PC_OFF;
  localparam logic [17:0] E_JMP  = K_PASS | G_ALU | L_PC | PC_BUS;
  localparam logic [17:0] E_LDR1 = G_MMX | L_MAR;
  localparam logic [17:0] E_LDR3 = G_MDR | L_REG | L_CC;
  localparam logic [17:0] E_STR1 = G_MMX | L_MAR | L_MDR | K_PASS;
  localparam logic [17:0] E_STR2 = M_WE;

  logic [17:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  string       tag;

  function automatic logic [17:0] e_alu(input logic [17:0] k, input logic ir5);
    return G_ALU | L_REG | L_CC | k | (ir5 ? SR2 : E_ZERO);
  endfunction

  task automatic push_fetch(input int n);
    exp_q.push_back(E_F1);
    for (int i = 0; i < n - 1; i++) exp_q.push_back(E_MRD);
    exp_q.push_back(E_MRDL);
    exp_q.push_back(E_F3);
    exp_q.push_back(E_DEC);
  endtask

  task automatic check_now();
    logic [17:0] got, want;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, got %h required an expected entry", tag, sel ? vb : va);
      return;
    end
    want = exp_q.pop_front();
    got  = sel ? vb : va;
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s #%0d: observed %h expected %h", tag, n_chk, got, want);
    end
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_now();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    Reset_n = 1'b0; Run_a = 1'b0; Run_b = 1'b0; Continue = 1'b0;
    IR_5 = 1'b0; BEN = 1'b0; Opcode = 4'h0; sel = 1'b0;

    tag = "reset";
    repeat (2) exp_q.push_back(E_ZERO);
    drain();
    Reset_n = 1'b1;
    tag = "halt_no_run";
    repeat (2) exp_q.push_back(E_ZERO);
    drain();

    // Run stays high from here on; it must be ignored outside HALTED.
    tag = "add_imm";
    Run_a = 1'b1; Opcode = 4'b0001; IR_5 = 1'b1;
    push_fetch(2); exp_q.push_back(e_alu(E_ZERO, 1'b1));
    drain();

    tag = "and_reg";
    Opcode = 4'b0101; IR_5 = 1'b0;
    push_fetch(2); exp_q.push_back(e_alu(K_AND, 1'b0));
    drain();

    tag = "not";
    Opcode = 4'b1001; IR_5 = 1'b1;
    push_fetch(2); exp_q.push_back(e_alu(K_NOT, 1'b1));
    drain();

    tag = "br_taken";
    Opcode = 4'b0000; BEN = 1'b1;
    push_fetch(2); exp_q.push_back(E_ZERO); exp_q.push_back(E_BRT);
    drain();

    tag = "br_not_taken";
    BEN = 1'b0;
    push_fetch(2); exp_q.push_back(E_ZERO);
    drain();

    tag = "jmp";
    Opcode = 4'b1100;
    push_fetch(2); exp_q.push_back(E_JMP);
    drain();

    tag = "pause_held";
    Opcode = 4'b1101; Continue = 1'b1;
    push_fetch(2); repeat (3) exp_q.push_back(E_ZERO);
    drain();
    tag = "pause_low";
    Continue = 1'b0;
    exp_q.push_back(E_ZERO);
    drain();

    tag = "pause_exit_str";
    Continue = 1'b1; Opcode = 4'b0111;
    push_fetch(2); exp_q.push_back(E_STR1); exp_q.push_back(E_STR2);
    drain();
    tag = "str2_second";
    exp_q.push_back(E_STR2);
    drain();

    tag = "reset_mid_str2";
    #2 Reset_n = 1'b0;
    #1 exp_q.push_back(E_ZERO);
    check_now();
    Continue = 1'b0; Run_a = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    tag = "halt_after_reset";
    repeat (3) exp_q.push_back(E_ZERO);
    drain();

    tag = "nop_undefined";
    Run_a = 1'b1; Opcode = 4'b1010;
    push_fetch(2); exp_q.push_back(E_F1);
    drain();

    tag = "reset_b";
    Reset_n = 1'b0; Run_a = 1'b0; sel = 1'b1;
    exp_q.push_back(E_ZERO);
    drain();
    Reset_n = 1'b1;

    tag = "ldr_wait3";
    Run_b = 1'b1; Opcode = 4'b0110;
    push_fetch(3);
    exp_q.push_back(E_LDR1);
    exp_q.push_back(E_MRD); exp_q.push_back(E_MRD); exp_q.push_back(E_MRDL);
    exp_q.push_back(E_LDR3);
    exp_q.push_back(E_F1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
